// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: instruction word type, NOP encoding, FIFO entry payload.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t NOP_INSTR        = 32'h0000_0013;
  localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;
  localparam word_t INSTR_BYTES      = 32'd4;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  // Clear the byte-offset bits so every fetch address is word aligned.
  function automatic word_t align_word(input word_t addr);
    return addr & ~word_t'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding fetched {pc, instr} entries; head is visible combinationally.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB separates the full and empty cases when indices match.
  always_comb begin
    count   = wr_ptr - rd_ptr;
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
              (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    do_pop  = pop && !flush && !empty;
    do_push = push && !flush && (!full || pop);
    head    = mem[rd_ptr[IDX_W-1:0]];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage needs no reset; pointers define which slots are meaningful.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[IDX_W-1:0]] <= wr_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Stage-1 instruction fetch: sequential PC generation, 1-cycle imem reads, buffered
// delivery to decode with NOP bubbles, decode stall and execute redirect handling.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter word_t       RESET_PC = RESET_PC_DEFAULT
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  stall,
  input  logic  redirect,
  input  word_t redirect_pc,
  output logic  imem_req,
  output word_t imem_addr,
  input  word_t imem_rdata,
  output word_t line,
  output word_t line_pc,
  output logic  line_valid
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  word_t          pc;
  word_t          inflight_pc;
  logic           inflight;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] occupancy;
  logic           empty;
  logic           push;
  logic           pop;
  fetch_entry_t   head;
  fetch_entry_t   wr_entry;

  // Only issue when the returning word is guaranteed a FIFO slot.
  always_comb begin
    occupancy = count + CNT_W'(inflight);
    imem_req  = !reset && !redirect && (occupancy < CNT_W'(DEPTH));
    imem_addr = pc;
  end

  // Redirect outranks everything: drops the inflight word and any pending pop.
  always_comb begin
    push           = inflight && !redirect;
    pop            = !empty && !stall && !redirect;
    wr_entry.pc    = inflight_pc;
    wr_entry.instr = imem_rdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      pc          <= align_word(redirect_pc);
      inflight    <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        pc          <= pc + INSTR_BYTES;
        inflight_pc <= pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (redirect),
    .wr_data (wr_entry),
    .head    (head),
    .count   (count),
    .empty   (empty)
  );

  // Decode sees the FIFO head directly, or a NOP bubble when nothing is buffered.
  always_comb begin
    line_valid = !empty;
    line       = empty ? NOP_INSTR : head.instr;
    line_pc    = head.pc;
  end

endmodule
